// File: rtl/sdram_wb_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_wb_prefetch_if
// Description : Bus bundle between the user-area Wishbone slave port, the
//               prefetch bridge and the SDRAM controller request port.
//               slave  - seen from the bridge (Wishbone in, controller out)
//               master - seen from whatever drives the Wishbone side and
//                        answers the controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_wb_prefetch_if;
  // Wishbone side
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  // Controller side
  logic [31:0] ctrl_addr;
  logic        ctrl_rw;
  logic [31:0] ctrl_wdata;
  logic [3:0]  ctrl_sel;
  logic        ctrl_in_valid;
  logic        ctrl_busy;
  logic [31:0] ctrl_rdata;
  logic        ctrl_out_valid;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  ctrl_busy, ctrl_rdata, ctrl_out_valid,
    output wbs_ack_o, wbs_dat_o,
    output ctrl_addr, ctrl_rw, ctrl_wdata, ctrl_sel, ctrl_in_valid
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output ctrl_busy, ctrl_rdata, ctrl_out_valid,
    input  wbs_ack_o, wbs_dat_o,
    input  ctrl_addr, ctrl_rw, ctrl_wdata, ctrl_sel, ctrl_in_valid
  );
endinterface
`default_nettype wire

// File: rtl/sdram_wb_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : sdram_wb_prefetch
// Description : Wishbone to SDRAM-controller bridge with a single-line read
//               prefetch buffer. Writes are write-through and merged into the
//               cached line when it holds the written address.
//               Optional feature macro: SDRAM_PREFETCH_EN
//                 defined   - line buffer of LINE_WORDS words, hits in 1 cycle
//                 undefined - every read is a single controller read
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               bus  - sdram_wb_prefetch_if.slave (Wishbone + controller)
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_wb_prefetch #(
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 32 - 2 - $clog2(LINE_WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  sdram_wb_prefetch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_FILL = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] ctrl_addr_q, ctrl_addr_d;
  logic        ctrl_rw_q, ctrl_rw_d;
  logic [31:0] ctrl_wdata_q, ctrl_wdata_d;
  logic [3:0]  ctrl_sel_q, ctrl_sel_d;
  logic        ctrl_in_valid_q, ctrl_in_valid_d;
  logic        valid;

  assign valid = bus.wbs_stb_i & bus.wbs_cyc_i;

`ifdef SDRAM_PREFETCH_EN
  localparam int IDX_W = $clog2(LINE_WORDS);

  logic [31:0]      line_buf_q [LINE_WORDS];
  logic [31:0]      line_buf_d [LINE_WORDS];
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             line_vld_q, line_vld_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;

  assign req_idx = bus.wbs_adr_i[2 +: IDX_W];
  assign req_tag = bus.wbs_adr_i[31 -: TAG_W];
  assign hit     = line_vld_q && (tag_q == req_tag);
  assign cnt_nxt = cnt_q + 1'b1;
`endif

  always_comb begin
    state_d         = state_q;
    ack_d           = 1'b0;
    dat_d           = dat_q;
    ctrl_addr_d     = ctrl_addr_q;
    ctrl_rw_d       = ctrl_rw_q;
    ctrl_wdata_d    = ctrl_wdata_q;
    ctrl_sel_d      = ctrl_sel_q;
    ctrl_in_valid_d = ctrl_in_valid_q;
`ifdef SDRAM_PREFETCH_EN
    line_buf_d      = line_buf_q;
    tag_d           = tag_q;
    line_vld_d      = line_vld_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
`endif
    unique case (state_q)
      IDLE: begin
        // ack_q blocks acceptance in the ack cycle so a held strobe is not
        // taken twice.
        if (valid && !ack_q) begin
          if (bus.wbs_we_i) begin
            state_d         = WR;
            ctrl_addr_d     = bus.wbs_adr_i & ~32'd3;
            ctrl_rw_d       = 1'b1;
            ctrl_wdata_d    = bus.wbs_dat_i;
            ctrl_sel_d      = bus.wbs_sel_i;
            ctrl_in_valid_d = ~bus.ctrl_busy;
          end else begin
`ifdef SDRAM_PREFETCH_EN
            idx_d = req_idx;
            if (hit) begin
              dat_d = line_buf_q[req_idx];
              ack_d = 1'b1;
            end else begin
              line_vld_d      = 1'b0;
              tag_d           = req_tag;
              cnt_d           = '0;
              state_d         = RD_FILL;
              ctrl_addr_d     = {req_tag, {IDX_W{1'b0}}, 2'b00};
              ctrl_rw_d       = 1'b0;
              ctrl_sel_d      = 4'd0;
              ctrl_in_valid_d = ~bus.ctrl_busy;
            end
`else
            state_d         = RD_FILL;
            ctrl_addr_d     = bus.wbs_adr_i & ~32'd3;
            ctrl_rw_d       = 1'b0;
            ctrl_sel_d      = 4'd0;
            ctrl_in_valid_d = ~bus.ctrl_busy;
`endif
          end
        end
      end

      RD_FILL: begin
        if (ctrl_in_valid_q && bus.ctrl_out_valid) begin
          // Dropping the request here gives the one-cycle gap between words.
          ctrl_in_valid_d = 1'b0;
`ifdef SDRAM_PREFETCH_EN
          line_buf_d[cnt_q] = bus.ctrl_rdata;
          if (cnt_q == IDX_W'(LINE_WORDS - 1)) begin
            line_vld_d = 1'b1;
            state_d    = RESP;
          end else begin
            cnt_d       = cnt_nxt;
            ctrl_addr_d = {tag_q, cnt_nxt, 2'b00};
          end
`else
          dat_d   = bus.ctrl_rdata;
          state_d = RESP;
`endif
        end else if (!ctrl_in_valid_q && !bus.ctrl_busy) begin
          ctrl_in_valid_d = 1'b1;
        end
      end

      WR: begin
        if (ctrl_in_valid_q && bus.ctrl_out_valid) begin
          ctrl_in_valid_d = 1'b0;
          ctrl_rw_d       = 1'b0;
          ctrl_sel_d      = 4'd0;
          ack_d           = valid;
          state_d         = IDLE;
`ifdef SDRAM_PREFETCH_EN
          // Keep the cached line coherent with the write-through data.
          if (line_vld_q && (tag_q == ctrl_addr_q[31 -: TAG_W])) begin
            for (int b = 0; b < 4; b++) begin
              if (ctrl_sel_q[b]) begin
                line_buf_d[ctrl_addr_q[2 +: IDX_W]][8*b +: 8] = ctrl_wdata_q[8*b +: 8];
              end
            end
          end
`endif
        end else if (!ctrl_in_valid_q && !bus.ctrl_busy) begin
          ctrl_in_valid_d = 1'b1;
        end
      end

      RESP: begin
`ifdef SDRAM_PREFETCH_EN
        dat_d = line_buf_q[idx_q];
`endif
        // An aborted cycle finishes its fill silently.
        ack_d   = valid;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      ack_q           <= 1'b0;
      dat_q           <= '0;
      ctrl_addr_q     <= '0;
      ctrl_rw_q       <= 1'b0;
      ctrl_wdata_q    <= '0;
      ctrl_sel_q      <= '0;
      ctrl_in_valid_q <= 1'b0;
`ifdef SDRAM_PREFETCH_EN
      line_buf_q      <= '{default: '0};
      tag_q           <= '0;
      line_vld_q      <= 1'b0;
      cnt_q           <= '0;
      idx_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      ack_q           <= ack_d;
      dat_q           <= dat_d;
      ctrl_addr_q     <= ctrl_addr_d;
      ctrl_rw_q       <= ctrl_rw_d;
      ctrl_wdata_q    <= ctrl_wdata_d;
      ctrl_sel_q      <= ctrl_sel_d;
      ctrl_in_valid_q <= ctrl_in_valid_d;
`ifdef SDRAM_PREFETCH_EN
      line_buf_q      <= line_buf_d;
      tag_q           <= tag_d;
      line_vld_q      <= line_vld_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
`endif
    end
  end

  assign bus.wbs_ack_o     = ack_q;
  assign bus.wbs_dat_o     = dat_q;
  assign bus.ctrl_addr     = ctrl_addr_q;
  assign bus.ctrl_rw       = ctrl_rw_q;
  assign bus.ctrl_wdata    = ctrl_wdata_q;
  assign bus.ctrl_sel      = ctrl_sel_q;
  assign bus.ctrl_in_valid = ctrl_in_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_wb_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_wb_prefetch
// Description : Self-checking bench for sdram_wb_prefetch. A behavioural
//               SDRAM controller with random latency answers requests; a
//               line-level reference model predicts read data, the exact
//               controller request list and hit latency per transaction.
//               Honours SDRAM_PREFETCH_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_wb_prefetch;
  localparam int LW   = 4;
  localparam int IDXW = $clog2(LW);

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wd;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_wb_prefetch_if bus();

  sdram_wb_prefetch #(.LINE_WORDS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- SDRAM storage (controller side and reference side) -----
  logic [31:0] sdram   [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
  endfunction

  function automatic logic [31:0] sdram_rd(input logic [31:0] a);
    return sdram.exists(a) ? sdram[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // ---------------- Behavioural controller ---------------------------------
  logic        c_busy, c_ov, c_wait;
  logic [31:0] c_rd;
  int          c_left;
  req_t        c_req;
  req_t        req_q[$];
  int          done_cnt = 0;

  assign bus.ctrl_busy      = c_busy;
  assign bus.ctrl_out_valid = c_ov;
  assign bus.ctrl_rdata     = c_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_busy <= 1'b0;
      c_ov   <= 1'b0;
      c_wait <= 1'b0;
      c_rd   <= '0;
      c_left <= 0;
    end else begin
      c_ov <= 1'b0;
      if (!bus.ctrl_in_valid) c_wait <= 1'b0;
      if (!c_busy && bus.ctrl_in_valid && !c_wait) begin
        c_req.rw   = bus.ctrl_rw;
        c_req.addr = bus.ctrl_addr;
        c_req.sel  = bus.ctrl_sel;
        c_req.wd   = bus.ctrl_wdata;
        req_q.push_back(c_req);
        c_busy <= 1'b1;
        c_left <= int'($urandom_range(1, 3));
      end else if (c_busy) begin
        if (c_left <= 1) begin
          logic [31:0] w;
          c_busy <= 1'b0;
          c_ov   <= 1'b1;
          c_wait <= 1'b1;
          w = sdram_rd(c_req.addr);
          if (c_req.rw) begin
            for (int b = 0; b < 4; b++)
              if (c_req.sel[b]) w[8*b +: 8] = c_req.wd[8*b +: 8];
            sdram[c_req.addr] = w;
          end
          c_rd <= w;
          done_cnt++;
        end else begin
          c_left <= c_left - 1;
        end
      end
    end
  end

  // ---------------- Monitors -------------------------------------------------
  logic prev_iv = 1'b0;
  int   ack_cnt = 0;
  always @(negedge clk) begin
    if (!rst && bus.ctrl_in_valid && !prev_iv)
      check("in_valid_rise_while_busy", 32'(bus.ctrl_busy), 32'd0);
    prev_iv = bus.ctrl_in_valid;
    if (bus.wbs_ack_o) ack_cnt++;
  end

  // ---------------- Reference model ------------------------------------------
  bit          mdl_vld  = 1'b0;
  logic [31:0] mdl_line = '0;
  req_t        exp_q[$];

  // Predicts the controller requests for one transaction, updates the model
  // memory/line state, and returns whether it is a one-cycle hit.
  task automatic model_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output bit hit, output logic [31:0] rd);
    req_t r;
    logic [31:0] wa, w, line;
    wa  = a & ~32'd3;
    hit = 1'b0;
    rd  = ref_rd(wa);
    exp_q.delete();
    if (we) begin
      w = ref_rd(wa);
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[wa] = w;
      r.rw = 1'b1; r.addr = wa; r.sel = s; r.wd = d;
      exp_q.push_back(r);
    end else begin
`ifdef SDRAM_PREFETCH_EN
      line = a >> (2 + IDXW);
      if (mdl_vld && mdl_line == line) begin
        hit = 1'b1;
      end else begin
        for (int i = 0; i < LW; i++) begin
          r.rw = 1'b0; r.addr = (line << (2 + IDXW)) + 32'(4 * i); r.sel = 4'd0; r.wd = '0;
          exp_q.push_back(r);
        end
        mdl_vld  = 1'b1;
        mdl_line = line;
      end
`else
      line = '0;
      r.rw = 1'b0; r.addr = wa; r.sel = 4'd0; r.wd = '0;
      exp_q.push_back(r);
`endif
    end
  endtask

  task automatic compare_reqs(input string pfx);
    check({pfx, "_nreq"}, 32'(req_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < req_q.size(); i++) begin
      check({pfx, "_req_addr"}, req_q[i].addr, exp_q[i].addr);
      check({pfx, "_req_rw"},   32'(req_q[i].rw), 32'(exp_q[i].rw));
      check({pfx, "_req_sel"},  32'(req_q[i].sel), 32'(exp_q[i].sel));
      if (exp_q[i].rw) check({pfx, "_req_wdata"}, req_q[i].wd, exp_q[i].wd);
    end
  endtask

  task automatic bus_idle();
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'd0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
  endtask

  task automatic bus_drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = s;
    bus.wbs_adr_i = a;
    bus.wbs_dat_i = d;
  endtask

  task automatic run_txn(input string pfx, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    bit          hit;
    logic [31:0] exp_d;
    int          lat;
    model_txn(we, a, d, s, hit, exp_d);
    req_q.delete();
    @(negedge clk);
    bus_drive(we, a, d, s);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.wbs_ack_o && lat < 200);
    check({pfx, "_ack"}, 32'(bus.wbs_ack_o), 32'd1);
    if (!we) check({pfx, "_rdata"}, bus.wbs_dat_o, exp_d);
    if (hit) check({pfx, "_hit_latency"}, 32'(lat), 32'd1);
    bus_idle();
    @(negedge clk);
    check({pfx, "_ack_width"}, 32'(bus.wbs_ack_o), 32'd0);
    compare_reqs(pfx);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_ack"},      32'(bus.wbs_ack_o), 32'd0);
    check({pfx, "_dat"},      bus.wbs_dat_o, 32'd0);
    check({pfx, "_in_valid"}, 32'(bus.ctrl_in_valid), 32'd0);
    check({pfx, "_addr"},     bus.ctrl_addr, 32'd0);
    check({pfx, "_rw"},       32'(bus.ctrl_rw), 32'd0);
    check({pfx, "_sel"},      32'(bus.ctrl_sel), 32'd0);
    check({pfx, "_wdata"},    bus.ctrl_wdata, 32'd0);
  endtask

  // ---------------- Main sequence --------------------------------------------
  initial begin
    bit          hit;
    logic [31:0] rd, a;
    int          a0, d0, n, need, total;
    bus_idle();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Cold line fill, sequential hits, coherent partial write, tag miss.
    run_txn("cold_rd",  1'b0, 32'h3800_0010, '0, 4'd0);
    run_txn("seq_rd14", 1'b0, 32'h3800_0014, '0, 4'd0);
    run_txn("seq_rd18", 1'b0, 32'h3800_0018, '0, 4'd0);
    run_txn("seq_rd1c", 1'b0, 32'h3800_001C, '0, 4'd0);
    run_txn("wr18",     1'b1, 32'h3800_0018, 32'hA5A5_A5A5, 4'b0011);
    run_txn("rd18_mrg", 1'b0, 32'h3800_0018, '0, 4'd0);
    run_txn("rd20_miss",1'b0, 32'h3800_0020, '0, 4'd0);

    // Abort during the fill: no ack, the line still completes.
    a = 32'h3800_0104;
    model_txn(1'b0, a, '0, 4'd0, hit, rd);
    total = exp_q.size();
`ifdef SDRAM_PREFETCH_EN
    need = 2;
`else
    need = 1;
`endif
    req_q.delete();
    a0 = ack_cnt;
    d0 = done_cnt;
    @(negedge clk);
    bus_drive(1'b0, a, '0, 4'd0);
    n = 0;
    while (done_cnt - d0 < need && n < 300) begin @(negedge clk); n++; end
    bus_idle();
    n = 0;
    while (done_cnt - d0 < total && n < 300) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    check("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
    compare_reqs("abort");
    run_txn("abort_reread", 1'b0, a, '0, 4'd0);

    // Randomized mix over a small window so hits, misses and merges recur.
    for (int i = 0; i < 40; i++) begin
      logic        we;
      logic [31:0] ra;
      we = ($urandom_range(0, 9) < 3);
      ra = 32'h3800_0000 + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
      run_txn("rand", we, ra, $urandom, 4'($urandom_range(1, 15)));
    end

    // Reset in the middle of a fill abandons the line.
    run_txn("pre_rst_fill", 1'b0, 32'h3800_0200, '0, 4'd0);
    model_txn(1'b0, 32'h3800_0300, '0, 4'd0, hit, rd);
    req_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    bus_drive(1'b0, 32'h3800_0300, '0, 4'd0);
    n = 0;
    while (done_cnt - d0 < 1 && n < 300) begin @(negedge clk); n++; end
    #2 rst = 1'b1;
    #1 check_outputs_zero("mid_rst");
    bus_idle();
    mdl_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn("post_rst_refill", 1'b0, 32'h3800_0200, '0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sdram_wb_prefetch.md
# sdram_wb_prefetch

Wishbone-to-SDRAM-controller bridge with a single-line read prefetch buffer. It sits between the user-area Wishbone slave port and `sdram_controller`. It turns each Wishbone cycle into one or more controller requests, and serves sequential reads from a line of `LINE_WORDS` words so that firmware fetch and data streams avoid a full SDRAM access per word. Writes are write-through and keep the buffer coherent.

## Interface
Parameters
- `LINE_WORDS`, 4: words per prefetch line; power of two, 2..16.
- `TAG_W`, 32-2-log2(`LINE_WORDS`): tag width, derived; do not override.

Ports
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone strobe, cycle and write enable.
- `wbs_sel_i` in 4: byte selects.
- `wbs_adr_i`, `wbs_dat_i` in 32 each: byte address and write data.
- `wbs_ack_o` out 1: one-cycle acknowledge.
- `wbs_dat_o` out 32: registered read data.
- `ctrl_addr` out 32: controller byte address, word aligned.
- `ctrl_rw` out 1: 1 = write.
- `ctrl_wdata` out 32: controller write data.
- `ctrl_sel` out 4: write byte mask. Equals `wbs_sel_i` during a write, 0 otherwise.
- `ctrl_in_valid` out 1: request valid.
- `ctrl_busy` in 1: controller busy.
- `ctrl_rdata` in 32: controller read data.
- `ctrl_out_valid` in 1: completion pulse for a read or a write.

## Operation
- `valid` = `wbs_stb_i & wbs_cyc_i`. A request is accepted only in IDLE with `wbs_ack_o`=0.
- Buffer state: `buf[LINE_WORDS]` x 32, `tag`, `line_vld`. Address split: word index = `adr[2+:log2(LINE_WORDS)]`, tag = `adr[31 -: TAG_W]`.
- FSM states: IDLE, RD_FILL, WR, RESP.
- IDLE, read hit (`line_vld` and tags equal):
  - `wbs_dat_o` <= `buf[idx]`.
  - Pulse ack. Stay in IDLE.
- IDLE, read miss:
  - Clear `line_vld` and latch the new tag.
  - Set fill counter to 0. Go to RD_FILL.
- RD_FILL:
  - Issue controller read at `{tag, cnt, 2'b00}` with `ctrl_in_valid`=1, holding addr and rw stable until `ctrl_out_valid`.
  - On `ctrl_out_valid`: capture `ctrl_rdata` into `buf[cnt]`, drop `ctrl_in_valid` for exactly one cycle, then increment `cnt`.
  - After word `LINE_WORDS-1`: set `line_vld`, go to RESP.
- WR:
  - Drive `ctrl_rw`=1, `ctrl_wdata`=`wbs_dat_i`, `ctrl_sel`=`wbs_sel_i`. Hold `ctrl_in_valid` until `ctrl_out_valid`.
  - Then, if the line is valid and the tag matches, merge the written bytes into `buf[idx]` per `sel`.
  - Pulse ack, go to IDLE.
- RESP:
  - `wbs_dat_o` <= `buf[idx]` of the latched address.
  - Ack only if `valid` is still high (abort handling). Go to IDLE.
- Wishbone abort (`cyc` dropped) during RD_FILL or WR: the controller transaction completes, the fill completes and the line becomes valid, and no ack is issued.
- Address, we and sel are latched at acceptance. Later changes on the Wishbone inputs are ignored until return to IDLE.
- `ctrl_busy` is advisory only: `ctrl_in_valid` never rises while `ctrl_busy`=1.
- Reset: FSM -> IDLE, `line_vld`=0, `cnt`=0. All outputs are 0, including `wbs_ack_o`, `wbs_dat_o`, `ctrl_in_valid` and `ctrl_addr`. A reset mid-fill abandons the transaction.

## Timing
- Read hit: `valid` sampled at edge N -> `wbs_ack_o`=1 and data valid during cycle N+1. Latency 1.
- Read miss: `ctrl_in_valid` rises at edge N+1. Each word takes controller latency L plus 1 gap cycle. The ack comes 1 cycle after the last `ctrl_out_valid` + 1 (RESP). Total: LINE_WORDS·(L+1)+2 cycles.
- Write: `ctrl_in_valid` rises at edge N+1. The ack comes in the cycle after `ctrl_out_valid`.
- `wbs_ack_o` is always exactly one cycle wide. No back-to-back acceptance occurs in the ack cycle.

## Configuration
- `SDRAM_PREFETCH_EN` defined: behaviour as above.
- `SDRAM_PREFETCH_EN` undefined:
  - The buffer, tag and RD_FILL line loop are removed.
  - Every read issues a single controller read at `wbs_adr_i & ~3`, then RESP returns `ctrl_rdata`. Read latency is L+2 and there are no hits.
  - Writes are unchanged, apart from having no merge step.

## Test plan
- Cold read 0x3800_0010 (`LINE_WORDS`=4):
  - Expect exactly 4 controller reads, at 0x..10, 0x..14, 0x..18, 0x..1C.
  - `wbs_dat_o` = SDRAM word at 0x..10; a single ack.
- Reads 0x..14, 0x..18, 0x..1C after the fill:
  - Each gets ack at latency 1 with the correct data.
  - Zero `ctrl_in_valid` pulses.
- Write 0xA5A5_A5A5 with sel=4'b0011 to 0x..18, then read 0x..18:
  - One controller write.
  - Read returns `{old[31:16], 16'hA5A5}` with no refill.
- Read 0x..20 (tag miss): 4 new controller reads; the old line is replaced.
- Drop `wbs_cyc_i` after controller word 1 of a fill:
  - The fill finishes and no ack is issued.
  - An immediate reread of the same address hits in 1 cycle.
- Assert `rst` mid-fill:
  - All outputs become 0 asynchronously.
  - The next read of the previously cached line misses and refills.
